pc_sequencer: RTL

Program-counter sequencer for the K1 processor. Holds the current instruction address, advances it by one on each accepted step, and on a jump instruction drives the jump stage: presents the count, raises a jump request, waits for completion and loads the returned target. It sits directly upstream of the jump stage and feeds it `currentCount` and `jumpEnable`. It consumes that stage's `jumpResult` and `jumpDone`.

---
 rtl/k1_pkg.sv | 10 +
 rtl/pc_sequencer_if.sv | 16 +
 rtl/pc_timeout.sv | 22 ++
 rtl/pc_sequencer.sv | 99 +++++++++
 4 files changed

// File: rtl/k1_pkg.sv
// k1_pkg: shared K1 definitions (sequencer state encoding, jump error code)
package k1_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        JREQ  = 2'd1,
        JWAIT = 2'd2,
        HALT  = 2'd3
    } pc_state_e;
    localparam logic [7:0] ERR_JUMP = "J";
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and jump-stage handshake bundle for pc_sequencer
interface pc_sequencer_if #(
    parameter int SIZE = 8
);
    logic            step, isJump, halt, jumpDone;
    logic [SIZE-1:0] jumpResult, currentCount;
    logic            jumpEnable, ready, halted, wrapped, jumpErr;
    modport master (
        output step, isJump, halt, jumpDone, jumpResult,
        input  currentCount, jumpEnable, ready, halted, wrapped, jumpErr
    );
    modport slave (
        input  step, isJump, halt, jumpDone, jumpResult,
        output currentCount, jumpEnable, ready, halted, wrapped, jumpErr
    );
endinterface

// File: rtl/pc_timeout.sv
// pc_timeout: loadable down-counter that pulses after TIMEOUT consecutive enabled cycles
module pc_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);
    logic [W-1:0] cnt_q, cnt_d;
    // reload on clear, count down while enabled, rest at zero
    always_comb cnt_d = clear_i ? LOAD : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    assign expire_o = en_i && cnt_q == '0;
    // counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: K1 program counter with jump-stage handshake; jump timeout enabled by PC_TIMEOUT_EN
module pc_sequencer
    import k1_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int END_ADDR = 255,
    parameter int TIMEOUT  = 16
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam logic [SIZE-1:0] END_A = SIZE'(END_ADDR);
    pc_state_e       state_q, state_d;
    logic [SIZE-1:0] count_q, count_d, next_seq;
    logic            halt_pend_q, halt_pend_d;
    logic            wrapped_q, wrapped_d, jerr_q, jerr_d;
    logic            at_end, target_ok, expire, done;
`ifdef PC_TIMEOUT_EN
    pc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == JREQ),
        .en_i     (state_q == JWAIT && !bus.jumpDone),
        .expire_o (expire)
    );
`else
    assign expire = TIMEOUT < 0;
`endif
    assign at_end    = count_q == END_A;
    assign next_seq  = at_end ? '0 : count_q + SIZE'(1);
    assign target_ok = int'(bus.jumpResult) <= END_ADDR;
    assign done      = bus.jumpDone || expire;
    // state and pending-halt registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
        end
    end
    // next state: halt wins in IDLE, JREQ masks jumpDone, halt during a jump waits for completion
    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        unique case (state_q)
            IDLE: begin
                state_d     = bus.halt ? HALT : (bus.step && bus.isJump) ? JREQ : IDLE;
                halt_pend_d = 1'b0;
            end
            JREQ: begin
                state_d     = JWAIT;
                halt_pend_d = halt_pend_q || bus.halt;
            end
            JWAIT: begin
                state_d     = !done ? JWAIT : (halt_pend_q || bus.halt) ? HALT : IDLE;
                halt_pend_d = !done && (halt_pend_q || bus.halt);
            end
            HALT: state_d = HALT;
        endcase
    end
    // datapath next values: sequential advance, jump load or reject, timeout fallback
    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        jerr_d    = 1'b0;
        if (state_q == IDLE && !bus.halt && bus.step && !bus.isJump) begin
            count_d   = next_seq;
            wrapped_d = at_end;
        end else if (state_q == JWAIT && bus.jumpDone) begin
            count_d = target_ok ? bus.jumpResult : count_q;
            jerr_d  = !target_ok;
        end else if (state_q == JWAIT && expire) begin
            count_d   = next_seq;
            wrapped_d = at_end;
            jerr_d    = 1'b1;
        end
    end
    // datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
            jerr_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            jerr_q    <= jerr_d;
        end
    end
    assign bus.currentCount = count_q;
    assign bus.jumpEnable   = state_q == JREQ || state_q == JWAIT;
    assign bus.ready        = state_q == IDLE;
    assign bus.halted       = state_q == HALT;
    assign bus.wrapped      = wrapped_q;
    assign bus.jumpErr      = jerr_q;
endmodule
